// File: rtl/pop_pkg.sv
// Shared types, register map and default durations for the POP sequence scheduler.
// POP_RAMSEY_EN selects the Ramsey sequence (MW1, FREE, MW2); undefined builds the Rabi sequence.
package pop_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPump,
    StDark,
    StMw1,
    StFree,
    StMw2,
    StProbe
  } state_e;

  localparam logic [2:0] ADDR_PUMP  = 3'd0;
  localparam logic [2:0] ADDR_DARK  = 3'd1;
  localparam logic [2:0] ADDR_MW    = 3'd2;
  localparam logic [2:0] ADDR_FREE  = 3'd3;
  localparam logic [2:0] ADDR_PROBE = 3'd4;
  localparam logic [2:0] ADDR_SDLY  = 3'd5;
  localparam logic [2:0] ADDR_SLEN  = 3'd6;
  localparam logic [2:0] ADDR_NCYC  = 3'd7;

  localparam int unsigned POP_DEF_PUMP  = 1000;
  localparam int unsigned POP_DEF_DARK  = 50;
  localparam int unsigned POP_DEF_MW    = 200;
  localparam int unsigned POP_DEF_FREE  = 2000;
  localparam int unsigned POP_DEF_PROBE = 500;

  // Phase order within one POP cycle; StIdle after StProbe marks the cycle boundary.
  function automatic state_e next_phase(input state_e st);
    state_e nxt;
    case (st)
      StPump:  nxt = StDark;
      StDark:  nxt = StMw1;
`ifdef POP_RAMSEY_EN
      StMw1:   nxt = StFree;
`else
      StMw1:   nxt = StProbe;
`endif
      StFree:  nxt = StMw2;
      StMw2:   nxt = StProbe;
      default: nxt = StIdle;
    endcase
    return nxt;
  endfunction

  function automatic logic [2:0] phase_addr(input state_e st);
    logic [2:0] a;
    case (st)
      StDark:        a = ADDR_DARK;
      StMw1, StMw2:  a = ADDR_MW;
      StFree:        a = ADDR_FREE;
      StProbe:       a = ADDR_PROBE;
      default:       a = ADDR_PUMP;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/pop_phase_timer.sv
// Loadable down-counter shared by all timed phases; expire is high while the count is zero.
module pop_phase_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock_2_5M,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             expire
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock_2_5M) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value  = cnt_q;
  assign expire = (cnt_q == '0);

endmodule

// File: rtl/pop_sequence_scheduler.sv
// POP clock-loop sequencer: pump, MW, probe and sample gates with double-buffered durations.
// Optional macro POP_RAMSEY_EN builds the Ramsey (FREE + MW2) sequence; default is Rabi.
module pop_sequence_scheduler
  import pop_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEF_PUMP  = POP_DEF_PUMP,
  parameter int unsigned DEF_DARK  = POP_DEF_DARK,
  parameter int unsigned DEF_MW    = POP_DEF_MW,
  parameter int unsigned DEF_FREE  = POP_DEF_FREE,
  parameter int unsigned DEF_PROBE = POP_DEF_PROBE
) (
  input  logic             clock_2_5M,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_wr,
  input  logic [2:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  output logic             pump,
  output logic             MW,
  output logic             probe,
  output logic             sample,
  output logic             busy,
  output logic             cycle_tick,
  output logic             done
);

  state_e           state_q, state_d, cand;
  logic [WIDTH-1:0] stg_q [8];
  logic [WIDTH-1:0] stg_d [8];
  logic [WIDTH-1:0] act_q [8];
  logic [WIDTH-1:0] act_d [8];
  logic [WIDTH-1:0] cyc_cnt_q, cyc_cnt_d, cyc_inc, cyc_next_inc;
  logic             stop_pend_q, stop_pend_d;
  logic             pump_q, mw_q, probe_q, sample_q, busy_q, tick_q, done_q;
  logic             pump_d, mw_d, probe_d, sample_d, busy_d, tick_d, done_d;
  logic             copy, advance, end_run, done_now, tick_now;
  logic             final_bnd, final_next, last_probe, wr_ok;
  logic             tmr_load, tmr_expire;
  logic [WIDTH-1:0] tmr_load_val, tmr_value, cnt_next, probe_idx;
  logic [WIDTH:0]   idx_ext, win_lo, win_hi;

  function automatic logic [WIDTH-1:0] reg_default(input int unsigned a);
    logic [WIDTH-1:0] rv;
    case (a)
      0:       rv = WIDTH'(DEF_PUMP);
      1:       rv = WIDTH'(DEF_DARK);
      2:       rv = WIDTH'(DEF_MW);
      3:       rv = WIDTH'(DEF_FREE);
      4:       rv = WIDTH'(DEF_PROBE);
      6:       rv = WIDTH'(1);
      default: rv = '0;
    endcase
    return rv;
  endfunction

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + WIDTH'(1);
  endfunction

  // First phase at or after 'from' with a nonzero duration; StIdle means the cycle ran out.
  function automatic state_e first_live(input state_e from, input logic [WIDTH-1:0] d [8]);
    state_e st;
    st = from;
    for (int i = 0; i < 6; i++) begin
      if (st != StIdle && d[phase_addr(st)] == '0) begin
        st = next_phase(st);
      end
    end
    return st;
  endfunction

`ifdef POP_RAMSEY_EN
  assign wr_ok = cfg_wr;
`else
  assign wr_ok = cfg_wr && (cfg_addr != ADDR_FREE);
`endif

  assign cyc_inc   = sat_inc(cyc_cnt_q);
  assign final_bnd = (act_q[ADDR_NCYC] != '0 && cyc_inc >= act_q[ADDR_NCYC]) ||
                     stop_pend_q || stop;
  assign advance   = (state_q == StIdle) ? start : tmr_expire;

  // Sequencing: phase advance, zero-length skipping and cycle-boundary handling.
  always_comb begin
    state_d   = state_q;
    cand      = StIdle;
    copy      = 1'b0;
    end_run   = 1'b0;
    done_now  = 1'b0;
    tick_now  = 1'b0;
    cyc_cnt_d = cyc_cnt_q;
    if (state_q == StIdle) begin
      if (start) begin
        copy      = 1'b1;
        cyc_cnt_d = '0;
        state_d   = first_live(StPump, stg_q);
        done_now  = (state_d == StIdle);
      end
    end else if (tmr_expire) begin
      cand = first_live(next_phase(state_q), act_q);
      if (cand != StIdle) begin
        state_d = cand;
      end else begin
        cyc_cnt_d = cyc_inc;
        if (state_q == StProbe) begin
          // The end-of-run decision was taken on entry to the last probe cycle.
          end_run = done_q;
        end else begin
          end_run  = final_bnd;
          tick_now = 1'b1;
          done_now = final_bnd;
        end
        if (end_run) begin
          state_d = StIdle;
        end else begin
          copy    = 1'b1;
          state_d = first_live(StPump, stg_q);
          if (state_d == StIdle) begin
            done_now = 1'b1;
          end
        end
      end
    end
  end

  // Staging/active registers; the copy sees staging before any same-edge write.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      stg_d[i] = stg_q[i];
      act_d[i] = copy ? stg_q[i] : act_q[i];
    end
    if (wr_ok) begin
      stg_d[cfg_addr] = cfg_data;
    end
  end

  // Next-state outputs, registered below.
  always_comb begin
    tmr_load     = advance && (state_d != StIdle);
    tmr_load_val = act_d[phase_addr(state_d)] - WIDTH'(1);
    if (tmr_load) begin
      cnt_next = tmr_load_val;
    end else if (tmr_expire) begin
      cnt_next = '0;
    end else begin
      cnt_next = tmr_value - WIDTH'(1);
    end
    probe_idx    = act_d[ADDR_PROBE] - WIDTH'(1) - cnt_next;
    idx_ext      = {1'b0, probe_idx};
    win_lo       = {1'b0, act_d[ADDR_SDLY]};
    win_hi       = {1'b0, act_d[ADDR_SDLY]} + {1'b0, act_d[ADDR_SLEN]};
    cyc_next_inc = sat_inc(cyc_cnt_d);
    final_next   = (act_d[ADDR_NCYC] != '0 && cyc_next_inc >= act_d[ADDR_NCYC]) ||
                   stop_pend_q || stop;
    last_probe   = (state_d == StProbe) && (cnt_next == '0);

    pump_d   = (state_d == StPump);
    mw_d     = (state_d == StMw1) || (state_d == StMw2);
    probe_d  = (state_d == StProbe);
    sample_d = probe_d && (idx_ext >= win_lo) && (idx_ext < win_hi);
    busy_d   = (state_d != StIdle);
    tick_d   = tick_now || last_probe;
    done_d   = done_now || (last_probe && final_next);

    stop_pend_d = (state_d == StIdle) ? 1'b0 :
                  (stop_pend_q || (stop && (state_q != StIdle || start)));
  end

  pop_phase_timer #(
    .WIDTH(WIDTH)
  ) u_timer (
    .clock_2_5M(clock_2_5M),
    .reset     (reset),
    .load      (tmr_load),
    .load_value(tmr_load_val),
    .value     (tmr_value),
    .expire    (tmr_expire)
  );

  always_ff @(posedge clock_2_5M) begin
    if (reset) begin
      state_q     <= StIdle;
      cyc_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
      pump_q      <= 1'b0;
      mw_q        <= 1'b0;
      probe_q     <= 1'b0;
      sample_q    <= 1'b0;
      busy_q      <= 1'b0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        stg_q[i] <= reg_default(i);
        act_q[i] <= reg_default(i);
      end
    end else begin
      state_q     <= state_d;
      cyc_cnt_q   <= cyc_cnt_d;
      stop_pend_q <= stop_pend_d;
      pump_q      <= pump_d;
      mw_q        <= mw_d;
      probe_q     <= probe_d;
      sample_q    <= sample_d;
      busy_q      <= busy_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
      for (int i = 0; i < 8; i++) begin
        stg_q[i] <= stg_d[i];
        act_q[i] <= act_d[i];
      end
    end
  end

  assign pump       = pump_q;
  assign MW         = mw_q;
  assign probe      = probe_q;
  assign sample     = sample_q;
  assign busy       = busy_q;
  assign cycle_tick = tick_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pop_sequence_scheduler.sv
// Self-checking bench for pop_sequence_scheduler: per-cycle gate traces against a phase-list model.
module tb_pop_sequence_scheduler;

`ifdef POP_RAMSEY_EN
  localparam bit RAMSEY = 1'b1;
`else
  localparam bit RAMSEY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, stop, cfg_wr;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        pump, MW, probe, sample, busy, cycle_tick, done;

  int checks = 0;
  int failures = 0;
  int cfg[8];
  logic [6:0] exp_q[$];
  logic [6:0] obs_q[$];

  pop_sequence_scheduler dut (
    .clock_2_5M(clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .cfg_wr    (cfg_wr),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .pump      (pump),
    .MW        (MW),
    .probe     (probe),
    .sample    (sample),
    .busy      (busy),
    .cycle_tick(cycle_tick),
    .done      (done)
  );

  always #200 clk = ~clk;

  // {busy, pump, MW, probe, sample, cycle_tick, done}
  function automatic logic [6:0] outs();
    return {busy, pump, MW, probe, sample, cycle_tick, done};
  endfunction

  task automatic set_defaults();
    cfg[0] = 1000; cfg[1] = 50; cfg[2] = 200; cfg[3] = 2000;
    cfg[4] = 500;  cfg[5] = 0;  cfg[6] = 1;   cfg[7] = 0;
  endtask

  // Expected outputs for one POP cycle, one entry per clock, from the phase durations.
  task automatic model_cycle(input int c[8], input bit last);
    logic s, t;
    for (int i = 0; i < c[0]; i++) exp_q.push_back(7'b1100000);
    for (int i = 0; i < c[1]; i++) exp_q.push_back(7'b1000000);
    for (int i = 0; i < c[2]; i++) exp_q.push_back(7'b1010000);
    if (RAMSEY) begin
      for (int i = 0; i < c[3]; i++) exp_q.push_back(7'b1000000);
      for (int i = 0; i < c[2]; i++) exp_q.push_back(7'b1010000);
    end
    for (int j = 0; j < c[4]; j++) begin
      s = (j >= c[5]) && (j < c[5] + c[6]);
      t = (j == c[4] - 1);
      exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, s, t, t && last});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    set_defaults();
  endtask

  task automatic write_cfg(input int a, input int d);
    @(negedge clk);
    cfg_wr   = 1'b1;
    cfg_addr = a[2:0];
    cfg_data = d[15:0];
    @(negedge clk);
    cfg_wr = 1'b0;
    cfg[a] = d;
  endtask

  task automatic set_basic();
    write_cfg(0, 10); write_cfg(1, 2); write_cfg(2, 3); write_cfg(3, 20);
    write_cfg(4, 8);  write_cfg(5, 0); write_cfg(6, 1); write_cfg(7, 1);
  endtask

  // Pulses start, then records n cycles of outputs; optional mid-run write and stop.
  task automatic run_capture(input int n, input int wr_at, input int wr_addr, input int wr_data,
                             input int stop_at, input bit stop_with_start);
    obs_q.delete();
    @(negedge clk);
    start = 1'b1;
    stop  = stop_with_start;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start  = 1'b0;
      stop   = 1'b0;
      cfg_wr = 1'b0;
      obs_q.push_back(outs());
      if (k == wr_at) begin
        cfg_wr   = 1'b1;
        cfg_addr = wr_addr[2:0];
        cfg_data = wr_data[15:0];
      end
      if (k == stop_at) stop = 1'b1;
    end
    start  = 1'b0;
    stop   = 1'b0;
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (outs() !== 7'b0) begin
        failures++;
        $display("FAIL reset_outputs cyc %0d got %b want %b", k, outs(), 7'b0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_defaults();
    write_cfg(7, 1);
    exp_q.delete();
    model_cycle(cfg, 1'b1);
    exp_q.push_back(7'b0);
    run_capture(exp_q.size(), -1, 0, 0, -1, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL defaults cyc %0d got %b want %b", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_basic();
    set_basic();
    exp_q.delete();
    model_cycle(cfg, 1'b1);
    exp_q.push_back(7'b0);
    exp_q.push_back(7'b0);
    run_capture(exp_q.size(), -1, 0, 0, -1, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL basic cyc %0d got %b want %b", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_sample();
    set_basic();
    for (int pass = 0; pass < 2; pass++) begin
      write_cfg(5, (pass == 0) ? 2 : 8);
      write_cfg(6, 10);
      exp_q.delete();
      model_cycle(cfg, 1'b1);
      exp_q.push_back(7'b0);
      run_capture(exp_q.size(), -1, 0, 0, -1, 1'b0);
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) begin
          failures++;
          $display("FAIL sample_sdly%0d cyc %0d got %b want %b", cfg[5], k, obs_q[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_zero();
    set_basic();
    write_cfg(1, 0);
    write_cfg(3, 0);
    exp_q.delete();
    model_cycle(cfg, 1'b1);
    exp_q.push_back(7'b0);
    run_capture(exp_q.size(), -1, 0, 0, -1, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL zero_len cyc %0d got %b want %b", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_midrun();
    int c_new[8];
    set_basic();
    write_cfg(7, 3);
    exp_q.delete();
    model_cycle(cfg, 1'b0);
    c_new = cfg;
    c_new[0] = 5;
    model_cycle(c_new, 1'b0);
    model_cycle(c_new, 1'b1);
    exp_q.push_back(7'b0);
    run_capture(exp_q.size(), cfg[0] + cfg[1], 0, 5, -1, 1'b0);
    cfg[0] = 5;
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL midrun_cfg cyc %0d got %b want %b", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_stop_idle();
    set_basic();
    write_cfg(7, 2);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    exp_q.delete();
    model_cycle(cfg, 1'b0);
    model_cycle(cfg, 1'b1);
    exp_q.push_back(7'b0);
    run_capture(exp_q.size(), -1, 0, 0, -1, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL stop_in_idle cyc %0d got %b want %b", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_start_stop();
    set_basic();
    write_cfg(7, 0);
    exp_q.delete();
    model_cycle(cfg, 1'b1);
    exp_q.push_back(7'b0);
    exp_q.push_back(7'b0);
    run_capture(exp_q.size(), -1, 0, 0, -1, 1'b1);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL start_stop cyc %0d got %b want %b", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_continuous_stop();
    int len;
    set_basic();
    write_cfg(7, 0);
    len = cfg[0] + cfg[1] + cfg[2] + cfg[4] + (RAMSEY ? cfg[3] + cfg[2] : 0);
    exp_q.delete();
    for (int c = 0; c < 4; c++) model_cycle(cfg, c == 3);
    exp_q.push_back(7'b0);
    exp_q.push_back(7'b0);
    run_capture(exp_q.size(), -1, 0, 0, 3 * len + len / 2, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL continuous_stop cyc %0d got %b want %b", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_all_zero();
    for (int a = 0; a < 7; a++) write_cfg(a, 0);
    write_cfg(7, 1);
    exp_q.delete();
    exp_q.push_back(7'b0000001);
    exp_q.push_back(7'b0);
    exp_q.push_back(7'b0);
    run_capture(exp_q.size(), -1, 0, 0, -1, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL all_zero cyc %0d got %b want %b", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      write_cfg(0, int'($urandom_range(1, 6)));
      write_cfg(1, int'($urandom_range(0, 3)));
      write_cfg(2, int'($urandom_range(0, 4)));
      write_cfg(3, int'($urandom_range(0, 5)));
      write_cfg(4, int'($urandom_range(1, 8)));
      write_cfg(5, int'($urandom_range(0, 9)));
      write_cfg(6, int'($urandom_range(0, 9)));
      write_cfg(7, int'($urandom_range(1, 3)));
      exp_q.delete();
      for (int c = 0; c < cfg[7]; c++) model_cycle(cfg, c == cfg[7] - 1);
      exp_q.push_back(7'b0);
      run_capture(exp_q.size(), -1, 0, 0, -1, 1'b0);
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) begin
          failures++;
          $display("FAIL random%0d cyc %0d got %b want %b", it, k, obs_q[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    int k_stop;
    set_basic();
    k_stop = cfg[0] + cfg[1] + cfg[2] + 2;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k <= k_stop; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_midrun_busy got %b want %b", busy, 1'b1);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== 7'b0) begin
      failures++;
      $display("FAIL reset_midrun_drop got %b want %b", outs(), 7'b0);
    end
    reset = 1'b0;
    set_defaults();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (outs() !== 7'b0) begin
        failures++;
        $display("FAIL reset_midrun_quiet cyc %0d got %b want %b", k, outs(), 7'b0);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    cfg_wr   = 1'b0;
    cfg_addr = 3'd0;
    cfg_data = 16'd0;
    set_defaults();
    test_reset();
    test_defaults();
    test_basic();
    test_sample();
    test_zero();
    test_midrun();
    test_stop_idle();
    test_start_stop();
    test_continuous_stop();
    test_all_zero();
    test_random();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
